// File: rtl/div_seq.sv
// Sequential signed divider (DIV): restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, with sign fix-up applied when the result is written.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_r;
    logic [CW-1:0]    count_r;
    logic             sign_q_r;
    logic             sign_r_r;

    logic             start_s;
    logic             zero_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH-1:0] diff_s;
    logic             fits_s;

    // Two's complement magnitude; the most negative value maps onto itself as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (-x) : x;
    endfunction

    // Next-state logic, start/zero decode and one restoring-division step.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        zero_s  = 1'b0;
        shift_s = {rem_r, dvd_r[WIDTH-1]};
        // When the trial subtraction fits, the true difference is below 2^WIDTH.
        diff_s  = shift_s[WIDTH-1:0] - dsr_r;
        fits_s  = (shift_s >= {1'b0, dsr_r});
        case (state_r)
            IDLE: begin
                if (div) begin
                    if (b == {WIDTH{1'b0}}) begin
                        zero_s = 1'b1;
                    end else begin
                        start_s = 1'b1;
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == LAST_ITER) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset abandons any division in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            dvd_r    <= {WIDTH{1'b0}};
            dsr_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            high     <= {WIDTH{1'b0}};
            low      <= {WIDTH{1'b0}};
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_s;
            div_end  <= 1'b0;
            div_zero <= zero_s;
            // busy covers the div_end cycle too, then follows the FSM.
            busy     <= (state_s != IDLE) || (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        dvd_r    <= magnitude(a);
                        dsr_r    <= magnitude(b);
                        rem_r    <= {WIDTH{1'b0}};
                        count_r  <= {CW{1'b0}};
                        sign_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r_r <= a[WIDTH-1];
                    end else begin
                        count_r <= count_r;
                    end
                end
                CALC: begin
                    rem_r   <= fits_s ? diff_s : shift_s[WIDTH-1:0];
                    dvd_r   <= {dvd_r[WIDTH-2:0], fits_s};
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                end
                DONE: begin
                    low     <= sign_q_r ? (-dvd_r) : dvd_r;
                    high    <= sign_r_r ? (-rem_r) : rem_r;
                    div_end <= 1'b1;
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule
